// File: rtl/seg7_scan_display.sv
// seg7_scan_display: binary value -> BCD via a one-shift-per-clock double-dabble engine,
// then time-multiplexed onto common-anode seven-segment digits. Includes leading-zero
// blanking, per-digit decimal points and dash display on overflow.
module seg7_scan_display #(
  parameter int DATA_W      = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 2000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic [DIGITS-1:0] dp_en,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_bcd_q, disp_bcd_d;
  logic               disp_ovf_q, disp_ovf_d;
  logic [BCD_W-1:0]   adj;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [DIGITS-1:0]  an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         cur_digit;
  logic               upper_zero;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a}; non-decimal codes go dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Converter next-state: load capture, add-3/shift iterations, atomic commit to display regs.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_acc_d  = ovf_acc_q;
    cnt_d      = cnt_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovf_d = disp_ovf_q;
    adj        = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d     = data;
          bcd_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(DATA_W);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d     = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d     = {bin_q[DATA_W-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | adj[BCD_W-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        disp_bcd_d = bcd_q;
        disp_ovf_d = ovf_acc_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Converter and committed-display registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_acc_q  <= 1'b0;
      cnt_q      <= '0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_acc_q  <= ovf_acc_d;
      cnt_q      <= cnt_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  // Refresh divider; each terminal count moves the scan to the next digit.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Scan position registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // Segment/anode/dp selection for the active digit: dashes beat blanking, blanking beats decode.
  always_comb begin
    cur_digit  = disp_bcd_q[4*int'(idx_q) +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (disp_bcd_q[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    an_d = ~(DIGITS'(1) << idx_q);
    if (disp_ovf_q) begin
      seg_d = 7'b0111111;
    end else if (LZ_BLANK && (idx_q != '0) && upper_zero) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = decode(cur_digit);
    end
    dp_d = ~dp_en[idx_q];
  end

  // Glitch-free registered display drive; everything dark straight after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign ovf  = disp_ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed stimulus with a value scoreboard; two instances share
// inputs, one with leading-zero blanking and one without.
module tb_seg7_scan_display;

  localparam int DATA_W = 14;
  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              load = 1'b0;
  logic [DIGITS-1:0] dp_en = '0;
  logic              busy, ovf, dp;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              busy_1, ovf_1, dp_1;
  logic [DIGITS-1:0] an_1;
  logic [6:0]        seg_1;

  int compared = 0;
  int mismatched = 0;
  int exp_q[$];

  seg7_scan_display #(.DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .data(data), .load(load), .dp_en(dp_en),
    .busy(busy), .ovf(ovf), .an(an), .seg(seg), .dp(dp));

  seg7_scan_display #(.DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .data(data), .load(load), .dp_en(dp_en),
    .busy(busy_1), .ovf(ovf_1), .an(an_1), .seg(seg_1), .dp(dp_1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int v, input int i, input bit lz);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (v >= 10000) return 7'b0111111;
    if (lz && (i != 0) && (v < p)) return 7'h7F;
    return enc((v / p) % 10);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one load pulse from the current negedge; returns at the next negedge.
  task automatic applyStimulus(input int v);
    data = DATA_W'(v);
    load = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Counts busy cycles (bounded); optionally drives a load that must be ignored.
  task automatic run_conversion(input int inject_at, input int inject_val, output int width);
    width = 0;
    while ((busy === 1'b1) && (width < 100)) begin
      width++;
      if (width == inject_at) begin
        data = DATA_W'(inject_val);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic wait_an(input logic [DIGITS-1:0] target, input string tag);
    int guard;
    guard = 0;
    while ((an !== target) && (guard < 40)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(tag, 32'(an), 32'(target));
  endtask

  // Pops the expected value and checks every digit of one full scan on both instances.
  task automatic check_display();
    int v;
    logic [DIGITS-1:0] target;
    logic exp_dp, exp_ovf;
    if (exp_q.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
      return;
    end
    v = exp_q.pop_front();
    exp_ovf = (v >= 10000);
    @(negedge clk);
    for (int i = 0; i < DIGITS; i++) begin
      target = ~(4'b0001 << i);
      exp_dp = ~dp_en[i];
      wait_an(target, $sformatf("an_d%0d", i));
      checkOutput("an_nolz", 32'(an_1), 32'(target));
      checkOutput($sformatf("seg_v%0d_d%0d", v, i), 32'(seg), 32'(model_seg(v, i, 1'b1)));
      checkOutput($sformatf("segnolz_v%0d_d%0d", v, i), 32'(seg_1), 32'(model_seg(v, i, 1'b0)));
      checkOutput("dp", 32'(dp), 32'(exp_dp));
      checkOutput("dp_nolz", 32'(dp_1), 32'(exp_dp));
      checkOutput("ovf", 32'(ovf), 32'(exp_ovf));
      checkOutput("ovf_nolz", 32'(ovf_1), 32'(exp_ovf));
      checkOutput("busy_idle", 32'(busy | busy_1), 32'd0);
    end
  endtask

  initial begin
    int w, k, v;
    logic [DIGITS-1:0] exp_an;
    logic exp_dp;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_dp", 32'(dp), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b1;

    // Scan sequence with committed value 0
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      k = ((n - 1) / RDIV) % DIGITS;
      exp_an = ~(4'b0001 << k);
      checkOutput($sformatf("scan_an_%0d", n), 32'(an), 32'(exp_an));
      checkOutput($sformatf("scan_seg_%0d", n), 32'(seg), 32'(model_seg(0, k, 1'b1)));
      checkOutput($sformatf("scan_segnolz_%0d", n), 32'(seg_1), 32'(model_seg(0, k, 1'b0)));
    end

    // 255: busy width and display
    applyStimulus(255);
    run_conversion(0, 0, w);
    checkOutput("busy_w_255", 32'(w), 32'(DATA_W + 1));
    check_display();

    // 9999 fits, 12345 overflows
    applyStimulus(9999);
    run_conversion(0, 0, w);
    checkOutput("busy_w_9999", 32'(w), 32'(DATA_W + 1));
    check_display();
    applyStimulus(12345);
    run_conversion(0, 0, w);
    check_display();

    // Reset on 7th busy cycle aborts 1234 and clears overflow
    applyStimulus(1234);
    repeat (6) @(negedge clk);
    checkOutput("busy_c7", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    checkOutput("abort_an", 32'(an), 32'hF);
    void'(exp_q.pop_back());
    exp_q.push_back(0);
    repeat (30) @(negedge clk);
    checkOutput("abort_no_commit_busy", 32'(busy), 32'd0);
    check_display();

    // Load while busy is dropped; back-to-back load on busy fall is accepted
    applyStimulus(255);
    run_conversion(3, 42, w);
    checkOutput("busy_w_drop", 32'(w), 32'(DATA_W + 1));
    check_display();
    applyStimulus(12345);
    run_conversion(0, 0, w);
    v = exp_q.pop_front();
    checkOutput("b2b_ovf", 32'(ovf), 32'(v >= 10000));
    applyStimulus(42);
    run_conversion(0, 0, w);
    checkOutput("busy_w_42", 32'(w), 32'(DATA_W + 1));
    check_display();

    // Decimal point on digit 2, then live toggling on digit 0
    dp_en = 4'b0100;
    applyStimulus(1234);
    run_conversion(0, 0, w);
    check_display();
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      exp_dp = (an === 4'b1011) ? 1'b0 : 1'b1;
      checkOutput($sformatf("dp_scan_%0d", n), 32'(dp), 32'(exp_dp));
    end
    wait_an(4'b0111, "dp_wait_d3");
    wait_an(4'b1110, "dp_wait_d0");
    checkOutput("dp_d0_before", 32'(dp), 32'd1);
    dp_en = 4'b0001;
    @(negedge clk);
    checkOutput("dp_d0_on", 32'(dp), 32'd0);
    dp_en = 4'b0000;
    @(negedge clk);
    checkOutput("dp_d0_off", 32'(dp), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
